fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 48 ++++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-side definitions.
//   XLEN / INSTR_BYTES : architectural widths used for PC arithmetic
//   fetch_state_e      : fetch unit control state
//   fetch_entry_t      : one queued instruction {pc, instr}
package riscv_pkg;
  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} queue between fetch and the consumer.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : drop all entries (wins over push/pop)
//   push/pop   : enqueue push_data / dequeue head; a push into a full queue
//                is accepted only when a pop frees a slot in the same cycle
//   head       : oldest entry (meaningful when !empty)
//   count/empty/full : occupancy
module fetch_fifo
  import riscv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         empty,
  output logic         full
);
  fetch_entry_t slots [2];
  logic         rd_ptr, wr_ptr;
  logic         do_push, do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == 2'd2);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) slots[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks a combinational instruction memory from
// RESET_PC, buffers fetched words in a 2-entry queue and hands them out with a
// valid/ready handshake. Redirects flush the queue and retarget the PC; a
// misaligned target parks the unit in FAULT.
//   clk, rst                 : clock, synchronous active-high reset
//   start                    : leave IDLE and begin fetching
//   imem_addr / imem_data    : combinational instruction memory port
//   out_valid/ready/instr/pc : instruction output handshake
//   redirect_valid/pc        : branch/jump retarget (ignored in IDLE)
//   halted, fault, fault_pc  : terminal state status
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned     MEM_BYTES = 80   // multiple of INSTR_BYTES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            halted,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);
  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] fault_pc_q;

  logic            redir, redir_ok, in_bound;
  logic            push, pop;
  logic            q_empty, q_full;
  logic [1:0]      q_count;
  fetch_entry_t    q_head, q_in;

  // Redirects only mean something once fetching has been started.
  assign redir    = redirect_valid && (state_q != ST_IDLE);
  assign redir_ok = (redirect_pc[1:0] == 2'b00);

  // 33-bit compare so a PC near 2^32 cannot wrap past the bound.
  assign in_bound = ({1'b0, pc_q} + 33'(INSTR_BYTES)) <= 33'(MEM_BYTES);

  // Redirect owns the cycle: no pop is counted, no push happens.
  assign pop  = !q_empty && out_ready && !redir;
  assign push = (state_q == ST_RUN) && !redir && in_bound && (!q_full || pop);

  assign q_in.pc    = pc_q;
  assign q_in.instr = imem_data;

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redir),
    .push      (push),
    .push_data (q_in),
    .pop       (pop),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

  assign imem_addr = pc_q;
  assign out_valid = !q_empty;
  assign out_instr = q_head.instr;
  assign out_pc    = q_head.pc;
  assign halted    = (state_q == ST_HALT);
  assign fault     = (state_q == ST_FAULT);
  assign fault_pc  = fault_pc_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (redir)          state_d = redir_ok ? ST_RUN : ST_FAULT;
        else if (!in_bound) state_d = ST_HALT;
      end
      ST_HALT, ST_FAULT: begin
        if (redir) state_d = redir_ok ? ST_RUN : ST_FAULT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      fault_pc_q <= '0;
    end else begin
      if (redir && redir_ok)  pc_q <= redirect_pc;
      else if (push)          pc_q <= pc_q + XLEN'(INSTR_BYTES);
      // Misaligned target leaves pc alone and records the culprit.
      if (redir && !redir_ok) fault_pc_q <= redirect_pc;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, out_ready, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_data, out_instr, out_pc, fault_pc;
  logic        out_valid, halted, fault;

  logic [31:0]  mem [32];
  fetch_entry_t sb [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(80)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .fault(fault), .fault_pc(fault_pc)
  );

  always_comb begin
    imem_data = 32'hDEAD_BEEF;
    if (imem_addr < 32'd80) imem_data = mem[imem_addr[6:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic push_all();
    fetch_entry_t e;
    for (int a = 0; a < 80; a += 4) begin
      e.pc    = 32'(a);
      e.instr = mem[a/4];
      sb.push_back(e);
    end
  endtask

  task automatic wait_halt();
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_pc == 32'd76) found = 1;
      else cyc();
    end
    chk("halt_seen_pc76", {31'b0, found}, 32'd1);
    cyc(); @(negedge clk);
    chk("halted_after_76", {31'b0, halted}, 32'd1);
    chk("halt_no_valid", {31'b0, out_valid}, 32'd0);
    cyc(); @(negedge clk);
    chk("halt_pc_held", imem_addr, 32'd80);
    chk("halt_sb_drained", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard consumer: every accepted handshake must match the oldest expectation.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (!rst && !redirect_valid && out_valid && out_ready) begin
      if (sb.size() == 0) chk("sb_extra_pc", out_pc, 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 | 32'(i * 4);
    mem[0] = 32'h00112E63;
    mem[1] = 32'h00A00093;
    mem[2] = 32'h01400113;
    mem[7] = 32'h00708193;

    rst = 1; start = 0; out_ready = 0; redirect_valid = 0; redirect_pc = 0;
    cyc(); cyc(); @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);

    // Redirect is ignored while idle.
    cyc(); rst = 0; redirect_valid = 1; redirect_pc = 32'd8;
    cyc(); redirect_valid = 0; @(negedge clk);
    chk("idle_redir_ignored", imem_addr, 32'd0);
    chk("idle_no_valid", {31'b0, out_valid}, 32'd0);

    // Streaming from reset, then free run to the end of memory.
    push_all();
    cyc(); start = 1; out_ready = 1;
    cyc(); start = 0; @(negedge clk);
    chk("first_cycle_no_valid", {31'b0, out_valid}, 32'd0);
    cyc(); @(negedge clk);
    chk("stream0_pc", out_pc, 32'd0);
    chk("stream0_instr", out_instr, 32'h00112E63);
    cyc(); @(negedge clk);
    chk("stream1_pc", out_pc, 32'd4);
    chk("stream1_instr", out_instr, 32'h00A00093);
    cyc(); @(negedge clk);
    chk("stream2_pc", out_pc, 32'd8);
    chk("stream2_instr", out_instr, 32'h01400113);
    wait_halt();

    // Backpressure: queue fills with 0 and 4, pc parks at 8.
    cyc(); rst = 1; out_ready = 0;
    cyc(); rst = 0;
    cyc(); start = 1;
    for (int i = 0; i < 5; i++) begin
      cyc(); start = 0; @(negedge clk);
      if (i >= 2) begin
        chk("bp_head_pc", out_pc, 32'd0);
        chk("bp_valid", {31'b0, out_valid}, 32'd1);
      end
    end
    chk("bp_addr", imem_addr, 32'd8);
    chk("bp_head_instr", out_instr, 32'h00112E63);
    for (int a = 0; a <= 8; a += 4) begin
      fetch_entry_t e;
      e.pc = 32'(a); e.instr = mem[a/4];
      sb.push_back(e);
    end
    cyc(); out_ready = 1;
    cyc(); cyc();
    cyc(); out_ready = 0; @(negedge clk);
    chk("bp_sb_drained", 32'(sb.size()), 32'd0);
    chk("bp_head_after", out_pc, 32'd12);

    // Redirect to 28 while full.
    cyc(); redirect_valid = 1; redirect_pc = 32'd28; out_ready = 1;
    cyc(); redirect_valid = 0; out_ready = 0; @(negedge clk);
    chk("redir_flush_valid", {31'b0, out_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'd28);
    cyc(); @(negedge clk);
    chk("redir_head_pc", out_pc, 32'd28);
    chk("redir_head_instr", out_instr, 32'h00708193);

    // Misaligned redirect, then recovery via aligned redirect.
    cyc(); redirect_valid = 1; redirect_pc = 32'h1E;
    cyc(); redirect_valid = 0; @(negedge clk);
    chk("fault_flag", {31'b0, fault}, 32'd1);
    chk("fault_pc", fault_pc, 32'h1E);
    chk("fault_valid", {31'b0, out_valid}, 32'd0);
    chk("fault_pc_unchanged", imem_addr, 32'd36);
    cyc(); @(negedge clk);
    chk("fault_held", {31'b0, fault}, 32'd1);
    chk("fault_no_fetch", imem_addr, 32'd36);
    cyc(); redirect_valid = 1; redirect_pc = 32'd0;
    cyc(); redirect_valid = 0; @(negedge clk);
    chk("recover_fault_clr", {31'b0, fault}, 32'd0);
    chk("recover_valid0", {31'b0, out_valid}, 32'd0);
    cyc(); @(negedge clk);
    chk("recover_head_pc", out_pc, 32'd0);
    chk("recover_valid1", {31'b0, out_valid}, 32'd1);

    // Reset mid-stream with two entries queued; rst beats everything else.
    cyc(); @(negedge clk);
    chk("pre_rst_head", out_pc, 32'd0);
    cyc(); rst = 1; start = 1; redirect_valid = 1; redirect_pc = 32'd40; out_ready = 1;
    cyc(); rst = 0; start = 0; redirect_valid = 0; out_ready = 0; @(negedge clk);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_addr", imem_addr, 32'd0);
    chk("mid_rst_fault", {31'b0, fault}, 32'd0);
    chk("mid_rst_halted", {31'b0, halted}, 32'd0);
    cyc(); @(negedge clk);
    chk("mid_rst_idle", {31'b0, out_valid}, 32'd0);
    push_all();
    cyc(); start = 1; out_ready = 1;
    cyc(); start = 0; @(negedge clk);
    chk("restart_no_valid", {31'b0, out_valid}, 32'd0);
    wait_halt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
